stft_interp_sequencer: RTL and testbench

- Sits between the STFT coefficient producer and the synthesis/output stage.
- Double-buffers per-bin STFT coefficient frames in a master bank (older frame) and a slave bank (newer frame).
- Instantiates the transformer block to compute the 3/4, 1/2 and 1/4 blends per bin.
- Each new frame is therefore played out as four sub-frames on a valid/ready stream, giving 4x temporal upsampling of the spectral frames.

---
 rtl/stft_interp_sequencer_pkg.sv | 16 +
 rtl/stft_interp_sequencer_transformer.sv | 31 +++
 rtl/stft_interp_sequencer.sv | 176 +++++++++++++++++
 tb/tb_stft_interp_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stft_interp_sequencer_pkg.sv
// rtl/stft_interp_sequencer_pkg.sv - shared constants and types for the STFT interpolation sequencer
package stft_pkg;

    localparam int COEFF_W = 28;

    localparam logic [1:0] PH_MASTER = 2'd0;
    localparam logic [1:0] PH_3Q     = 2'd1;
    localparam logic [1:0] PH_HALF   = 2'd2;
    localparam logic [1:0] PH_1Q     = 2'd3;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/stft_interp_sequencer_transformer.sv
// rtl/stft_interp_sequencer_transformer.sv - floor blends of master/slave coefficients at 3/4, 1/2, 1/4
module transformer
    import stft_pkg::*;
(
    input  logic               en,
    input  logic [COEFF_W-1:0] master_coeff,
    input  logic [COEFF_W-1:0] slave_coeff,
    output logic [COEFF_W-1:0] three_quarters,
    output logic [COEFF_W-1:0] half,
    output logic [COEFF_W-1:0] quarter
);

    logic [COEFF_W+1:0] m_ext;
    logic [COEFF_W+1:0] s_ext;
    logic [COEFF_W+1:0] sum_3q;
    logic [COEFF_W+1:0] sum_half;
    logic [COEFF_W+1:0] sum_1q;

    // Two guard bits make 3m+s and m+3s exact; the shifted results always fit back in COEFF_W
    always_comb begin
        m_ext          = {2'b00, master_coeff};
        s_ext          = {2'b00, slave_coeff};
        sum_3q         = (m_ext << 1) + m_ext + s_ext;
        sum_half       = m_ext + s_ext;
        sum_1q         = m_ext + (s_ext << 1) + s_ext;
        three_quarters = en ? sum_3q[COEFF_W+1:2] : '0;
        half           = en ? sum_half[COEFF_W:1] : '0;
        quarter        = en ? sum_1q[COEFF_W+1:2] : '0;
    end

endmodule

// File: rtl/stft_interp_sequencer.sv
// rtl/stft_interp_sequencer.sv - double-buffered STFT frame store played out as four blended sub-frames
module stft_interp_sequencer
    import stft_pkg::*;
#(
    parameter int NUM_BINS = 64,
    parameter int BIN_W    = $clog2(NUM_BINS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COEFF_W-1:0]        in_coeff,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COEFF_W-1:0]        out_coeff,
    output logic [BIN_W-1:0]          out_bin,
    output logic [1:0]                out_phase,
    output logic                      out_last,
    output logic                      primed,
    output logic                      frame_err
);

    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(NUM_BINS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   wr_bin;
    logic [BIN_W-1:0]   rd_bin;
    logic [1:0]         phase;
    logic               mst_sel;

    logic [COEFF_W-1:0] bank0 [NUM_BINS];
    logic [COEFF_W-1:0] bank1 [NUM_BINS];

    logic               in_acc;
    logic               wr_last_bin;
    logic               out_load;
    logic               play_last;
    logic [COEFF_W-1:0] master_coeff;
    logic [COEFF_W-1:0] slave_coeff;
    logic [COEFF_W-1:0] blend_3q;
    logic [COEFF_W-1:0] blend_half;
    logic [COEFF_W-1:0] blend_1q;
    logic [COEFF_W-1:0] next_coeff;

    assign in_acc      = in_valid & in_ready;
    assign wr_last_bin = (wr_bin == MAX_BIN);
    assign out_load    = (state == S_PLAY) && (!out_valid || out_ready);
    assign play_last   = (rd_bin == MAX_BIN) && (phase == PH_1Q);

    // Master bank is named by mst_sel; the slave bank is always the other one
    always_comb begin
        master_coeff = mst_sel ? bank1[rd_bin] : bank0[rd_bin];
        slave_coeff  = mst_sel ? bank0[rd_bin] : bank1[rd_bin];
    end

    transformer u_transformer (
        .en             (1'b1),
        .master_coeff   (master_coeff),
        .slave_coeff    (slave_coeff),
        .three_quarters (blend_3q),
        .half           (blend_half),
        .quarter        (blend_1q)
    );

    // Select the coefficient for the current sub-frame
    always_comb begin
        next_coeff = master_coeff;
        case (phase)
            PH_3Q:   next_coeff = blend_3q;
            PH_HALF: next_coeff = blend_half;
            PH_1Q:   next_coeff = blend_1q;
            default: next_coeff = master_coeff;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and input handshake
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_acc && wr_last_bin && primed) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (out_load && play_last) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Bank write: incoming frames always land in the slave bank; contents survive reset
    always_ff @(posedge clk) begin
        if (in_acc) begin
            if (mst_sel) begin
                bank0[wr_bin] <= in_coeff;
            end else begin
                bank1[wr_bin] <= in_coeff;
            end
        end
    end

    // Counters, bank select and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bin    <= '0;
            rd_bin    <= '0;
            phase     <= PH_MASTER;
            mst_sel   <= 1'b0;
            primed    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (in_acc) begin
                wr_bin <= wr_bin + 1'b1;
                if (in_last != wr_last_bin) begin
                    frame_err <= 1'b1;
                end
                if (wr_last_bin) begin
                    if (!primed) begin
                        mst_sel <= ~mst_sel;
                        primed  <= 1'b1;
                    end else begin
                        rd_bin <= '0;
                        phase  <= PH_MASTER;
                    end
                end
            end
            if (out_load) begin
                rd_bin <= rd_bin + 1'b1;
                if (rd_bin == MAX_BIN) begin
                    phase <= phase + 2'd1;
                end
                if (play_last) begin
                    mst_sel <= ~mst_sel;
                    wr_bin  <= '0;
                end
            end
        end
    end

    // Output register: loads when empty or being consumed, otherwise holds under back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_coeff <= '0;
            out_bin   <= '0;
            out_phase <= PH_MASTER;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_last  <= play_last;
            out_coeff <= next_coeff;
            out_bin   <= rd_bin;
            out_phase <= phase;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stft_interp_sequencer.sv
// tb/tb_stft_interp_sequencer.sv - self-checking bench for stft_interp_sequencer
module tb_stft_interp_sequencer;

    localparam int NB = 4;
    localparam int CW = 28;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_coeff;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_coeff;
    logic [1:0]    out_bin;
    logic [1:0]    out_phase;
    logic          out_last;
    logic          primed;
    logic          frame_err;

    stft_interp_sequencer #(.NUM_BINS(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeff  (in_coeff),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coeff (out_coeff),
        .out_bin   (out_bin),
        .out_phase (out_phase),
        .out_last  (out_last),
        .primed    (primed),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] coeff;
        logic [1:0]    bin;
        logic [1:0]    phase;
        logic          last;
    } beat_t;

    typedef struct {
        logic [CW-1:0] m;
        logic [CW-1:0] s;
        logic [CW-1:0] e0;
        logic [CW-1:0] e1;
        logic [CW-1:0] e2;
        logic [CW-1:0] e3;
    } vec_t;

    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    beats_seen = 0;
    bit    stall_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, a beat transfers on the next rising edge
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                beats_seen++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got coeff=%0h bin=%0d phase=%0d, expected none",
                             out_coeff, out_bin, out_phase);
                end else begin
                    e = sb.pop_front();
                    if (out_coeff !== e.coeff || out_bin !== e.bin ||
                        out_phase !== e.phase || out_last !== e.last) begin
                        errors++;
                        $display("FAIL beat: got coeff=%0h bin=%0d phase=%0d last=%0b expected coeff=%0h bin=%0d phase=%0d last=%0b",
                                 out_coeff, out_bin, out_phase, out_last, e.coeff, e.bin, e.phase, e.last);
                    end
                end
            end
            if (rst_n && sb.size() > 0) begin
                checks++;
                if (in_ready && !(sb.size() == 1 && out_valid && out_last)) begin
                    errors++;
                    $display("FAIL in_ready_during_play: got 1 expected 0 (pending=%0d)", sb.size());
                end
            end
        end
    end

    // Random back-pressure driver
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push_expect(input logic [CW-1:0] e0, input logic [CW-1:0] e1,
                               input logic [CW-1:0] e2, input logic [CW-1:0] e3);
        beat_t b;
        logic [CW-1:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int ph = 0; ph < 4; ph++) begin
            for (int bn = 0; bn < NB; bn++) begin
                b.coeff = ev[ph];
                b.bin   = 2'(bn);
                b.phase = 2'(ph);
                b.last  = (ph == 3) && (bn == NB - 1);
                sb.push_back(b);
            end
        end
    endtask

    task automatic send_frame(input logic [CW-1:0] val, input int last_pos);
        int n;
        for (int b = 0; b < NB; b++) begin
            in_valid = 1'b1;
            in_coeff = val;
            in_last  = (b == last_pos);
            n = 0;
            while (!in_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                errors++;
                checks++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_pending"}, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[5];
    int   seen0;

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_coeff  = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{m: 28'd100, s: 28'd200, e0: 28'd100, e1: 28'd125, e2: 28'd150, e3: 28'd175};
        vecs[1] = '{m: 28'd1,   s: 28'd2,   e0: 28'd1,   e1: 28'd1,   e2: 28'd1,   e3: 28'd1};
        vecs[2] = '{m: 28'hFFFFFFF, s: 28'hFFFFFFF, e0: 28'hFFFFFFF, e1: 28'hFFFFFFF, e2: 28'hFFFFFFF, e3: 28'hFFFFFFF};
        vecs[3] = '{m: 28'd200, s: 28'd0,   e0: 28'd200, e1: 28'd150, e2: 28'd100, e3: 28'd50};
        vecs[4] = '{m: 28'd0,   s: 28'd200, e0: 28'd0,   e1: 28'd50,  e2: 28'd100, e3: 28'd150};

        // Reset values
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_coeff", out_coeff, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_primed", primed, 0);
        chk("rst_frame_err", frame_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Table: prime with m, play s
        for (int i = 0; i < 5; i++) begin
            do_reset();
            send_frame(vecs[i].m, NB - 1);
            chk($sformatf("vec%0d_primed", i), primed, 1);
            repeat (5) @(negedge clk);
            chk($sformatf("vec%0d_no_out_after_prime", i), out_valid, 0);
            send_frame(vecs[i].s, NB - 1);
            push_expect(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
            drain($sformatf("vec%0d", i));
        end

        // Bank swap: A, B, then C all zero uses B as master
        do_reset();
        send_frame(28'd100, NB - 1);
        send_frame(28'd200, NB - 1);
        push_expect(28'd100, 28'd125, 28'd150, 28'd175);
        drain("ab");
        send_frame(28'd0, NB - 1);
        push_expect(28'd200, 28'd150, 28'd100, 28'd50);
        drain("c");

        // Random back-pressure during B, then C back-to-back while last beat may be pending
        do_reset();
        send_frame(28'd100, NB - 1);
        stall_en = 1'b1;
        send_frame(28'd200, NB - 1);
        push_expect(28'd100, 28'd125, 28'd150, 28'd175);
        send_frame(28'd0, NB - 1);
        push_expect(28'd200, 28'd150, 28'd100, 28'd50);
        drain("stall");
        stall_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;

        // Framing error: in_last on bin 2
        do_reset();
        send_frame(28'd100, 2);
        chk("frame_err_set", frame_err, 1);
        send_frame(28'd200, NB - 1);
        push_expect(28'd100, 28'd125, 28'd150, 28'd175);
        drain("ferr");
        chk("frame_err_sticky", frame_err, 1);

        // Reset mid-play at phase 2, bin 1
        do_reset();
        send_frame(28'd100, NB - 1);
        send_frame(28'd200, NB - 1);
        push_expect(28'd100, 28'd125, 28'd150, 28'd175);
        begin
            int n;
            n = 0;
            while (!(out_valid && out_phase == 2 && out_bin == 1) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("midplay_reached", out_valid && out_phase == 2 && out_bin == 1, 1);
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_coeff", out_coeff, 0);
        chk("midrst_out_bin", out_bin, 0);
        chk("midrst_out_phase", out_phase, 0);
        chk("midrst_primed", primed, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen0 = beats_seen;
        send_frame(28'd50, NB - 1);
        repeat (30) @(negedge clk);
        chk("post_rst_primed", primed, 1);
        chk("post_rst_no_beats", beats_seen - seen0, 0);
        chk("post_rst_in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
